// File: rtl/matrix_frame_buffer.sv
// Double-buffered row-addressed frame store. Rows are written into the back bank,
// the banks swap on a display frame boundary, then the new front is copied back.
module matrix_frame_buffer #(
   parameter int ROWS  = 16,
   parameter int COLS  = 32,
   parameter int ROW_W = 4,
   parameter int CNT_W = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic [ROW_W-1:0]           wr_row,
   input  logic [COLS-1:0]            wr_data,
   input  logic                       wr_last,
   input  logic                       frame_start,
   output logic [ROWS-1:0][COLS-1:0]  frame_out,
   output logic                       swap_pending,
   output logic [CNT_W-1:0]           frame_count
);

   typedef enum logic [1:0] {S_WRITE, S_PENDING, S_COPY} state_t;

   state_t                    state_q, state_d;
   logic                      front_sel_q, front_sel_d;
   logic [CNT_W-1:0]          frame_count_q, frame_count_d;
   logic [ROW_W-1:0]          copy_row_q, copy_row_d;
   logic [ROWS-1:0][COLS-1:0] bank0_q, bank0_d;
   logic [ROWS-1:0][COLS-1:0] bank1_q, bank1_d;
   logic [ROWS-1:0][COLS-1:0] front_bank;

   logic                      back_we;
   logic [ROW_W-1:0]          back_row;
   logic [COLS-1:0]           back_data;

   assign front_bank   = front_sel_q ? bank1_q : bank0_q;
   assign frame_out    = front_bank;
   assign frame_count  = frame_count_q;

   always_comb begin
      state_d       = state_q;
      front_sel_d   = front_sel_q;
      frame_count_d = frame_count_q;
      copy_row_d    = copy_row_q;
      wr_ready      = 1'b0;
      swap_pending  = 1'b0;
      back_we       = 1'b0;
      back_row      = '0;
      back_data     = '0;
      case (state_q)
         S_WRITE: begin
            wr_ready = 1'b1;
            if (wr_valid) begin
               back_we   = 1'b1;
               back_row  = wr_row;
               back_data = wr_data;
               if (wr_last) state_d = S_PENDING;
            end
         end
         S_PENDING: begin
            swap_pending = 1'b1;
            if (frame_start) begin
               front_sel_d   = ~front_sel_q;
               frame_count_d = frame_count_q + CNT_W'(1);
               state_d       = S_COPY;
            end
         end
         S_COPY: begin
            // Refresh the back bank from the front so the writer can send deltas.
            back_we    = 1'b1;
            back_row   = copy_row_q;
            back_data  = front_bank[copy_row_q];
            copy_row_d = copy_row_q + ROW_W'(1);
            if (copy_row_q == ROW_W'(ROWS-1)) begin
               copy_row_d = '0;
               state_d    = S_WRITE;
            end
         end
         default: state_d = S_WRITE;
      endcase
   end

   always_comb begin
      bank0_d = bank0_q;
      bank1_d = bank1_q;
      if (back_we) begin
         if (front_sel_q) bank0_d[back_row] = back_data;
         else             bank1_d[back_row] = back_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_WRITE;
         front_sel_q   <= 1'b0;
         frame_count_q <= '0;
         copy_row_q    <= '0;
         bank0_q       <= '0;
         bank1_q       <= '0;
      end else begin
         state_q       <= state_d;
         front_sel_q   <= front_sel_d;
         frame_count_q <= frame_count_d;
         copy_row_q    <= copy_row_d;
         bank0_q       <= bank0_d;
         bank1_q       <= bank1_d;
      end
   end

endmodule
